// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement controller.
// Allocates a rename tag (the tail pointer) per issued instruction and
// captures results from the common data bus. Entries retire strictly in
// issue order, one per cycle, through a registered commit port.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   issue_valid/issue_rd -> issue_tag, rob_full (combinational)
//   cdb_valid/cdb_tag/cdb_value : result broadcast
//   flush_in                    : drop every in-flight entry
//   commit_signal/commit_rd_value/commit_rd_tag/commit_rd_id : registered
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 rob_full,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  input  logic                 flush_in,
  output logic                 commit_signal,
  output logic [31:0]          commit_rd_value,
  output logic [ROB_WIDTH-1:0] commit_rd_tag,
  output logic [4:0]           commit_rd_id
);
  localparam int DEPTH = 1 << ROB_WIDTH;

  logic [DEPTH-1:0]         busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0][4:0]    rd_q, rd_d;
  logic [DEPTH-1:0][31:0]   value_q, value_d;
  logic [ROB_WIDTH-1:0]     head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]       count_q, count_d;
  logic                     csig_q, csig_d;
  logic [31:0]              cval_q, cval_d;
  logic [ROB_WIDTH-1:0]     ctag_q, ctag_d;
  logic [4:0]               cid_q, cid_d;

  logic do_issue, do_retire, do_wb;

  // One slot stays free so the retiring tag never equals the tag on offer.
  assign rob_full  = (count_q == (ROB_WIDTH+1)'(DEPTH-1));
  assign issue_tag = tail_q;

  // All decisions use pre-edge state, so a CDB write to head only makes
  // it retire-eligible on the following edge.
  assign do_issue  = issue_valid & ~rob_full;
  assign do_retire = busy_q[head_q] & ready_q[head_q];
  assign do_wb     = cdb_valid & busy_q[cdb_tag];

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    csig_d  = 1'b0;
    cval_d  = cval_q;
    ctag_d  = ctag_q;
    cid_d   = cid_q;
    if (flush_in) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_wb) begin
        ready_d[cdb_tag] = 1'b1;
        value_d[cdb_tag] = cdb_value;
      end
      // Retire clears after writeback so a late CDB hit on the retiring
      // head cannot resurrect it.
      if (do_retire) begin
        csig_d          = 1'b1;
        cval_d          = value_q[head_q];
        ctag_d          = head_q;
        cid_d           = rd_q[head_q];
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + ROB_WIDTH'(1);
      end
      // tail is never busy (free slot reserve), so this cannot collide
      // with the writeback or retire above.
      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = issue_rd;
        tail_d          = tail_q + ROB_WIDTH'(1);
      end
      if (do_issue && !do_retire)      count_d = count_q + (ROB_WIDTH+1)'(1);
      else if (!do_issue && do_retire) count_d = count_q - (ROB_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      rd_q    <= '0;
      value_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      csig_q  <= 1'b0;
      cval_q  <= '0;
      ctag_q  <= '0;
      cid_q   <= '0;
    end else if (rdy_in) begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      value_q <= value_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      csig_q  <= csig_d;
      cval_q  <= cval_d;
      ctag_q  <= ctag_d;
      cid_q   <= cid_d;
    end
  end

  assign commit_signal   = csig_q;
  assign commit_rd_value = cval_q;
  assign commit_rd_tag   = ctag_q;
  assign commit_rd_id    = cid_q;
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int RW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, rdy = 1'b1;
  logic          iv = 1'b0, cv = 1'b0, fl = 1'b0;
  logic [4:0]    ird = '0;
  logic [RW-1:0] ctag = '0;
  logic [31:0]   cval = '0;
  logic [RW-1:0] issue_tag, commit_rd_tag;
  logic          rob_full, commit_signal;
  logic [31:0]   commit_rd_value;
  logic [4:0]    commit_rd_id;

  reorder_buffer #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue_valid(iv), .issue_rd(ird), .issue_tag(issue_tag), .rob_full(rob_full),
    .cdb_valid(cv), .cdb_tag(ctag), .cdb_value(cval), .flush_in(fl),
    .commit_signal(commit_signal), .commit_rd_value(commit_rd_value),
    .commit_rd_tag(commit_rd_tag), .commit_rd_id(commit_rd_id)
  );

  int checks = 0, failures = 0;

  // Reference model: in-flight instructions as an ordered queue.
  typedef struct {
    int         tag;
    logic [4:0] rd;
    bit         rdy;
    logic [31:0] val;
  } ent_t;
  ent_t rob[$];
  int   m_tail = 0;
  logic        e_sig = 0;
  logic [31:0] e_val = 0;
  logic [RW-1:0] e_tag = 0;
  logic [4:0]  e_id = 0;

  task automatic model_step();
    bit full, ret;
    ent_t e;
    if (rst) begin
      rob.delete(); m_tail = 0; e_sig = 0; e_val = 0; e_tag = 0; e_id = 0;
    end else if (rdy) begin
      if (fl) begin
        rob.delete(); m_tail = 0; e_sig = 0;
      end else begin
        full = (rob.size() == DEPTH-1);
        ret  = (rob.size() > 0) && rob[0].rdy;
        if (ret) begin
          e_sig = 1; e_val = rob[0].val; e_tag = RW'(rob[0].tag); e_id = rob[0].rd;
          void'(rob.pop_front());
        end else e_sig = 0;
        if (cv) foreach (rob[i]) if (rob[i].tag == int'(ctag)) begin
          rob[i].rdy = 1; rob[i].val = cval;
        end
        if (iv && !full) begin
          e.tag = m_tail; e.rd = ird; e.rdy = 0; e.val = 0;
          rob.push_back(e);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  // One clock: drive inputs, step model at the edge, return at negedge.
  task automatic cyc(input bit i_v = 0, input logic [4:0] i_rd = 0,
                     input bit c_v = 0, input logic [RW-1:0] c_t = 0,
                     input logic [31:0] c_val = 0, input bit f = 0);
    iv = i_v; ird = i_rd; cv = c_v; ctag = c_t; cval = c_val; fl = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
    iv = 0; cv = 0; fl = 0;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (commit_signal !== 1'b0 || issue_tag !== 4'd0 || rob_full !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got sig=%0b tag=%0d full=%0b exp 0/0/0",
                 i, commit_signal, issue_tag, rob_full);
      end
      cyc();
    end
  endtask

  task automatic test_in_order();
    do_reset();
    cyc(1, 5'd5); cyc(1, 5'd6);
    cyc(0, 0, 1, 4'd1, 32'h22);
    checks++;
    if (commit_signal !== 1'b0) begin
      failures++; $display("FAIL in_order_no_early got=%0b exp=0", commit_signal);
    end
    cyc(0, 0, 1, 4'd0, 32'h11);
    checks++;
    if (commit_signal !== 1'b0) begin
      failures++; $display("FAIL in_order_latency got=%0b exp=0", commit_signal);
    end
    cyc();
    checks++;
    if (commit_signal !== 1'b1 || commit_rd_value !== 32'h11 || commit_rd_id !== 5'd5 || commit_rd_tag !== 4'd0) begin
      failures++;
      $display("FAIL in_order_first got sig=%0b val=%0h id=%0d tag=%0d exp 1/11/5/0",
               commit_signal, commit_rd_value, commit_rd_id, commit_rd_tag);
    end
    cyc();
    checks++;
    if (commit_signal !== 1'b1 || commit_rd_value !== 32'h22 || commit_rd_id !== 5'd6 || commit_rd_tag !== 4'd1) begin
      failures++;
      $display("FAIL in_order_second got sig=%0b val=%0h id=%0d tag=%0d exp 1/22/6/1",
               commit_signal, commit_rd_value, commit_rd_id, commit_rd_tag);
    end
    cyc();
    checks++;
    if (commit_signal !== 1'b0) begin
      failures++; $display("FAIL in_order_end got=%0b exp=0", commit_signal);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH-1; i++) cyc(1, 5'(i + 1));
    checks++;
    if (issue_tag !== 4'd15 || rob_full !== 1'b1) begin
      failures++; $display("FAIL full_after_15 got tag=%0d full=%0b exp 15/1", issue_tag, rob_full);
    end
    cyc(1, 5'd31);
    checks++;
    if (issue_tag !== 4'd15 || rob_full !== 1'b1) begin
      failures++; $display("FAIL full_16th_ignored got tag=%0d full=%0b exp 15/1", issue_tag, rob_full);
    end
    cyc(0, 0, 1, 4'd0, 32'hA0);
    // Retire edge with a simultaneous issue: issue blocked by pre-edge full.
    cyc(1, 5'd30);
    checks++;
    if (commit_signal !== 1'b1 || commit_rd_tag !== 4'd0 || commit_rd_value !== 32'hA0 ||
        issue_tag !== 4'd15 || rob_full !== 1'b0) begin
      failures++;
      $display("FAIL full_retire got sig=%0b ctag=%0d val=%0h itag=%0d full=%0b exp 1/0/a0/15/0",
               commit_signal, commit_rd_tag, commit_rd_value, issue_tag, rob_full);
    end
    cyc(1, 5'd29);
    checks++;
    if (issue_tag !== 4'd0 || rob_full !== 1'b1) begin
      failures++; $display("FAIL wrap_tag got tag=%0d full=%0b exp 0/1", issue_tag, rob_full);
    end
  endtask

  task automatic test_stray_cdb();
    do_reset();
    cyc(0, 0, 1, 4'd7, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (commit_signal !== 1'b0) begin
        failures++; $display("FAIL stray_no_commit got=%0b exp=0", commit_signal);
      end
    end
    for (int i = 0; i < 8; i++) cyc(1, 5'(i + 8));
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 4'(i), 32'(i * 3));
    // tags 0..6 drain, then tag 7 must sit waiting
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (commit_signal !== e_sig || commit_rd_tag !== e_tag || commit_rd_value !== e_val) begin
        failures++;
        $display("FAIL stray_drain got sig=%0b tag=%0d val=%0h exp %0b/%0d/%0h",
                 commit_signal, commit_rd_tag, commit_rd_value, e_sig, e_tag, e_val);
      end
      cyc();
    end
    checks++;
    if (commit_signal !== 1'b0 || commit_rd_tag !== 4'd6) begin
      failures++; $display("FAIL stray_tag7_waits got sig=%0b tag=%0d exp 0/6", commit_signal, commit_rd_tag);
    end
    cyc(0, 0, 1, 4'd7, 32'h77);
    cyc();
    checks++;
    if (commit_signal !== 1'b1 || commit_rd_tag !== 4'd7 || commit_rd_value !== 32'h77 || commit_rd_id !== 5'd15) begin
      failures++;
      $display("FAIL stray_tag7_commit got sig=%0b tag=%0d val=%0h id=%0d exp 1/7/77/15",
               commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1));
    cyc(0, 0, 1, 4'd1, 32'h1);
    cyc(0, 0, 1, 4'd2, 32'h2);
    cyc(1, 5'd9, 1, 4'd0, 32'h3, 1);
    checks++;
    if (commit_signal !== 1'b0 || issue_tag !== 4'd0 || rob_full !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got sig=%0b tag=%0d full=%0b exp 0/0/0", commit_signal, issue_tag, rob_full);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 4'(i), 32'hBAD);
      checks++;
      if (commit_signal !== 1'b0) begin
        failures++; $display("FAIL flush_no_old_commit cyc=%0d got=%0b exp=0", i, commit_signal);
      end
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1));
    cyc(0, 0, 1, 4'd0, 32'h10);
    cyc(0, 0, 1, 4'd1, 32'h20);
    cyc(0, 0, 1, 4'd2, 32'h30);
    cyc(0, 0, 1, 4'd3, 32'h55);
    for (int i = 0; i < 20 && !found; i++) begin
      if (commit_signal === 1'b1 && commit_rd_tag === 4'd3) found = 1;
      else cyc();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL stall_wait_tag3 got=timeout exp=commit of tag 3");
    end
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 5'd7, 1, 4'd4, 32'h99);
      checks++;
      if (commit_signal !== 1'b1 || commit_rd_tag !== 4'd3 || commit_rd_value !== 32'h55 || commit_rd_id !== 5'd4) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got sig=%0b tag=%0d val=%0h id=%0d exp 1/3/55/4",
                 i, commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id);
      end
    end
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (commit_signal !== 1'b0) begin
        failures++; $display("FAIL stall_single_commit cyc=%0d got=%0b exp=0", i, commit_signal);
      end
    end
  endtask

  task automatic test_random();
    bit i_v, c_v, f;
    logic [RW-1:0] t;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      i_v = ($urandom_range(0, 9) < 6);
      c_v = ($urandom_range(0, 1) == 1);
      f   = ($urandom_range(0, 99) < 2);
      if (rob.size() > 0 && $urandom_range(0, 3) != 0)
        t = RW'(rob[$urandom_range(0, rob.size()-1)].tag);
      else
        t = RW'($urandom_range(0, DEPTH-1));
      cyc(i_v, 5'($urandom), c_v, t, $urandom, f);
      checks++;
      if (commit_signal !== e_sig || commit_rd_value !== e_val ||
          commit_rd_tag !== e_tag || commit_rd_id !== e_id) begin
        failures++;
        $display("FAIL rand_commit n=%0d got %0b/%0h/%0d/%0d exp %0b/%0h/%0d/%0d", n,
                 commit_signal, commit_rd_value, commit_rd_tag, commit_rd_id, e_sig, e_val, e_tag, e_id);
      end
      checks++;
      if (issue_tag !== RW'(m_tail) || rob_full !== (rob.size() == DEPTH-1)) begin
        failures++;
        $display("FAIL rand_alloc n=%0d got tag=%0d full=%0b exp %0d/%0b", n,
                 issue_tag, rob_full, m_tail, rob.size() == DEPTH-1);
      end
    end
    rdy = 1;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_stray_cdb();
    test_flush();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement controller that sequences writes into the register file. It allocates a rename tag per issued instruction and captures execution results from the common data bus. It retires entries strictly in issue order, driving the register file's commit port (signal, value, tag) one instruction per cycle. It is the sole producer of the tags the register file stores and of every register-file commit.

## Interface
Parameters:
- ROB_WIDTH, 4, tag width; depth DEPTH = 2^ROB_WIDTH entries, usable capacity DEPTH-1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  ready; when low, no state changes
- issue_valid  input  1  allocate an entry this cycle
- issue_rd  input  5  destination register id of issuing instruction
- issue_tag  output  ROB_WIDTH  tag the next issue receives (= tail pointer), combinational
- rob_full  output  1  high when count == DEPTH-1, combinational
- cdb_valid  input  1  execution result broadcast
- cdb_tag  input  ROB_WIDTH  tag of broadcast result
- cdb_value  input  32  broadcast result value
- flush_in  input  1  discard all in-flight entries
- commit_signal  output  1  registered; one register-file commit this cycle
- commit_rd_value  output  32  registered; committed value
- commit_rd_tag  output  ROB_WIDTH  registered; committed tag
- commit_rd_id  output  5  registered; committed destination id (debug/trace)

## Operation
- Storage per entry: busy, ready, rd (5b), value (32b). Pointers head, tail (ROB_WIDTH, wrap modulo DEPTH); count (ROB_WIDTH+1 bits).
- Reset: all busy/ready = 0, head = tail = count = 0, commit_signal = 0, commit_rd_value = 0, commit_rd_tag = 0, commit_rd_id = 0. rob_full = 0, issue_tag = 0 after reset.
- Update condition: every action below occurs only on a posedge with rdy_in = 1. With rdy_in = 0, all state, including the commit outputs, holds.
- Priority order: reset > flush > normal.
- Issue: issue_valid & ~rob_full causes the following:
  - entry[tail] gets busy = 1, ready = 0, rd = issue_rd;
  - tail increments.
  - issue_valid while rob_full is ignored (no allocation, no pointer move). The issuer must not rely on it.
- Writeback: cdb_valid & busy[cdb_tag] sets ready = 1 and value = cdb_value. A broadcast to a non-busy entry is ignored.
- Retire: busy[head] & ready[head] causes the following:
  - next-cycle commit_signal = 1, commit_rd_value = value[head], commit_rd_tag = head, commit_rd_id = rd[head];
  - busy[head] and ready[head] clear, and head increments.
  - Otherwise commit_signal = 0; the other commit outputs hold their last values.
- At most one retire per cycle. Entries with rd = 0 still retire and pulse commit_signal; the register file ignores x0.
- count: +1 on issue only, -1 on retire only, unchanged when both or neither occur.
- Capacity reserve: one slot is kept free. This guarantees that the tag being presented on commit_rd_tag is never the tag handed out by issue_tag in that same cycle, so the register file never sees tag reuse on the commit cycle.
- Flush: clears all busy/ready, sets head = tail = count = 0 and commit_signal = 0. Issue, writeback and retire in the flush cycle are discarded.
- Rename-table cleanup in the register file is out of scope.

## Timing
- issue_tag and rob_full are combinational from the pointers/count. Issue is sampled at edge E; issue_tag advances after E.
- Writeback and retire decisions in the same edge do not interact: a CDB write to head at edge E makes head retire-eligible at edge E+1.
- Earliest latency: CDB at edge E, head retires at edge E+1, and commit_signal is high during the cycle following E+1 for exactly one cycle per retired entry.
- Back-to-back ready entries retire on consecutive edges, giving a continuous commit_signal.
- Simultaneous issue and retire at count = DEPTH-1: retire proceeds; issue is blocked because rob_full reflects the pre-edge count.
- Wrap-around: tail/head roll from DEPTH-1 to 0 with no bubble.
- Stall with rdy_in low while commit_signal = 1: the output stays high until the next ready edge. The register file acts only on a ready edge, so exactly one commit lands.

## Test plan
- Reset then idle: after rst_in is held 2 cycles, commit_signal = 0, issue_tag = 0, rob_full = 0, and they stay so for 10 idle cycles.
- In-order retire:
  - stimulus: issue rd=5 (tag 0) and rd=6 (tag 1); CDB tag 1 = 0x22, then CDB tag 0 = 0x11;
  - required response: no commit after the tag-1 CDB. The tag-0 commit (value 0x11, id 5) follows, then on the very next cycle the tag-1 commit (0x22, id 6).
- Full and wrap:
  - stimulus: issue 15 entries (ROB_WIDTH=4), then issue again;
  - required response: rob_full = 1 after the 15th and the 16th issue is ignored (issue_tag stays 15). After head retires, one more issue gets tag 15, the next gets tag 0.
- Stray CDB: CDB to a non-busy tag 7 with value 0xDEAD produces no ready flag and no commit. A later issue allocating tag 7 still waits for its own CDB.
- Flush mid-stream:
  - stimulus: 4 entries in flight, 2 ready, flush_in pulsed together with issue_valid and cdb_valid;
  - required response: the next cycle has commit_signal = 0, count = 0, issue_tag = 0, and no later commits from the old entries.
- rdy_in stall: rdy_in is dropped for 3 cycles while commit_signal = 1 (tag 3, value 0x55). The outputs hold unchanged for those 3 cycles, and no second commit of tag 3 occurs after rdy_in returns.
